// File: rtl/cpu_fetch_pkg.sv
// Shared fetch definitions: state encoding and datapath widths.
// Imported by the fetch unit, the core and the instruction memory model.
package cpu_fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_INC  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_e;

endpackage : cpu_fetch_pkg

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads words from a multi-cycle
// instruction memory over a read/busywait handshake and presents each
// fetched word to the core with a valid flag until it is consumed.
//
// Ports:
//   CLK, RESET          clock, async active-low reset
//   PC                  byte address being fetched / presented
//   INSTRUCTION         fetched word, meaningful while INSTR_VALID
//   INSTR_VALID         INSTRUCTION holds the word at PC
//   STALL               core cannot take the presented word this cycle
//   BRANCH_TAKEN        redirect request, sampled on a consume edge
//   BRANCH_TARGET       redirect byte address
//   MISALIGNED          sticky: taken branch to a non-word-aligned target
//   IMEM_READ           read request to instruction memory
//   IMEM_ADDR           word address (PC[IMEM_AW+1:2])
//   IMEM_READDATA       memory read data
//   IMEM_BUSYWAIT       memory not ready
module instr_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     IMEM_AW  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    output logic [PC_W-1:0]      PC,
    output logic [INSTR_W-1:0]   INSTRUCTION,
    output logic                 INSTR_VALID,
    input  logic                 STALL,
    input  logic                 BRANCH_TAKEN,
    input  logic [PC_W-1:0]      BRANCH_TARGET,
    output logic                 MISALIGNED,
    output logic                 IMEM_READ,
    output logic [IMEM_AW-1:0]   IMEM_ADDR,
    input  logic [INSTR_W-1:0]   IMEM_READDATA,
    input  logic                 IMEM_BUSYWAIT
);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                misaligned_q, misaligned_d;
    logic                imem_read_q, imem_read_d;
    logic                instr_valid_q, instr_valid_d;

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            misaligned_q  <= 1'b0;
            imem_read_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            misaligned_q  <= misaligned_d;
            imem_read_q   <= imem_read_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Next-state, PC update and registered handshake outputs
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    instr_d = IMEM_READDATA;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!STALL) begin
                    if (BRANCH_TAKEN) begin
                        pc_d = BRANCH_TARGET;
                        if (BRANCH_TARGET[1:0] != 2'b00) begin
                            misaligned_d = 1'b1;
                            state_d      = ST_ERROR;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        pc_d    = pc_q + PC_W'(PC_INC);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        // Decoded from the next state so the flops match the state register
        imem_read_d   = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_HOLD);
    end

    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_VALID = instr_valid_q;
    assign MISALIGNED  = misaligned_q;
    assign IMEM_READ   = imem_read_q;
    assign IMEM_ADDR   = pc_q[IMEM_AW+1:2];

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized stream of stalls, branches and memory latencies checked
// against a PC/memory reference model.
module tb_instr_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        MISALIGNED;
    logic        IMEM_READ;
    logic [7:0]  IMEM_ADDR;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (8)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PC            (PC),
        .INSTRUCTION   (INSTRUCTION),
        .INSTR_VALID   (INSTR_VALID),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .MISALIGNED    (MISALIGNED),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instruction memory model with configurable busywait per read
    logic [31:0] mem [256];
    int unsigned cfg_wait  = 0;
    bit          rand_wait = 1'b0;
    int unsigned cur_wait  = 0;
    int unsigned cnt       = 0;

    always_ff @(posedge CLK) begin
        if (!IMEM_READ) begin
            cnt <= 0;
        end else if (IMEM_BUSYWAIT) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
            if (rand_wait) cur_wait <= $urandom_range(0, 3);
        end
    end

    always_comb begin
        IMEM_BUSYWAIT = IMEM_READ && (cnt < (rand_wait ? cur_wait : cfg_wait));
        // Garbage while busy so an early capture is visible
        IMEM_READDATA = IMEM_BUSYWAIT ? ~mem[IMEM_ADDR] : mem[IMEM_ADDR];
    end

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return mem[int'((pc >> 2) % 256)];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) until a word is presented; returns cycles waited
    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!INSTR_VALID && n < max) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(INSTR_VALID), 32'd1);
    endtask

    // One consume edge with the given branch request, then stall again
    task automatic consume(input logic taken, input logic [31:0] target);
        STALL         = 1'b0;
        BRANCH_TAKEN  = taken;
        BRANCH_TARGET = target;
        tick();
        STALL         = 1'b1;
        BRANCH_TAKEN  = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        tk;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0004_0005;

        RESET = 1'b0; STALL = 1'b1; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
        #12;
        check("rst_pc", PC, 32'h0);
        check("rst_instr", INSTRUCTION, 32'h0);
        check("rst_valid", 32'(INSTR_VALID), 32'd0);
        check("rst_misal", 32'(MISALIGNED), 32'd0);
        check("rst_read", 32'(IMEM_READ), 32'd0);

        // Reset release, zero-wait: valid two cycles later
        @(posedge CLK); #1; RESET = 1'b1;
        check("idle_read", 32'(IMEM_READ), 32'd0);
        tick();
        check("first_read", 32'(IMEM_READ), 32'd1);
        check("first_valid", 32'(INSTR_VALID), 32'd0);
        tick();
        check("first_valid2", 32'(INSTR_VALID), 32'd1);
        check("first_instr", INSTRUCTION, 32'h0004_0005);
        check("first_pc", PC, 32'h0);

        // Stall six cycles in HOLD
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_pc", PC, 32'h0);
            check("stall_instr", INSTRUCTION, 32'h0004_0005);
            check("stall_valid", 32'(INSTR_VALID), 32'd1);
            check("stall_read", 32'(IMEM_READ), 32'd0);
        end
        cfg_wait = 3;
        consume(1'b0, 32'h0);
        check("cons_pc", PC, 32'h4);
        check("cons_valid", 32'(INSTR_VALID), 32'd0);

        // Three busywait cycles: address held for four cycles
        n = 0;
        while (IMEM_READ && n < 10) begin
            check("bw_addr", 32'(IMEM_ADDR), 32'h1);
            n++;
            tick();
        end
        check("bw_read_cycles", 32'(n), 32'd4);
        check("bw_valid", 32'(INSTR_VALID), 32'd1);
        check("bw_instr", INSTRUCTION, mem[1]);
        consume(1'b0, 32'h0);
        wait_valid(10, n);
        check("consume_gap", 32'(n + 1), 32'd5);
        check("pc8", PC, 32'h8);
        check("pc8_instr", INSTRUCTION, mem[2]);

        // Aligned branch at PC=8
        cfg_wait = 0;
        consume(1'b1, 32'h40);
        check("br_pc", PC, 32'h40);
        check("br_addr", 32'(IMEM_ADDR), 32'h10);
        check("br_read", 32'(IMEM_READ), 32'd1);
        wait_valid(10, n);
        check("br_instr", INSTRUCTION, mem[16]);

        // PC wrap from the top of the address space
        consume(1'b1, 32'hFFFF_FFFC);
        check("top_addr", 32'(IMEM_ADDR), 32'hFF);
        wait_valid(10, n);
        check("top_instr", INSTRUCTION, mem[255]);
        consume(1'b0, 32'h0);
        check("wrap_pc", PC, 32'h0);
        wait_valid(10, n);
        check("wrap_instr", INSTRUCTION, mem[0]);

        // Randomized stream against the reference model
        rand_wait = 1'b1;
        exp_pc = 32'h0;
        for (int i = 0; i < 150; i++) begin
            check("rnd_pc", PC, exp_pc);
            check("rnd_instr", INSTRUCTION, model_word(exp_pc));
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                BRANCH_TAKEN = 1'b1;
                BRANCH_TARGET = $urandom;
                tick();
                check("rnd_stall_pc", PC, exp_pc);
                check("rnd_stall_valid", 32'(INSTR_VALID), 32'd1);
            end
            tk  = ($urandom_range(0, 3) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            consume(tk, tgt);
            exp_pc = tk ? tgt : exp_pc + 32'd4;
            wait_valid(20, n);
        end
        rand_wait = 1'b0;
        cfg_wait  = 0;

        // Misaligned branch: sticky error, no further reads
        consume(1'b1, 32'h42);
        check("mis_flag", 32'(MISALIGNED), 32'd1);
        check("mis_pc", PC, 32'h42);
        check("mis_valid", 32'(INSTR_VALID), 32'd0);
        for (int i = 0; i < 8; i++) begin
            STALL = 1'($urandom);
            BRANCH_TAKEN = 1'($urandom);
            BRANCH_TARGET = $urandom & 32'hFFFF_FFFC;
            tick();
            check("err_read", 32'(IMEM_READ), 32'd0);
            check("err_misal", 32'(MISALIGNED), 32'd1);
            check("err_valid", 32'(INSTR_VALID), 32'd0);
            check("err_pc", PC, 32'h42);
        end
        STALL = 1'b1; BRANCH_TAKEN = 1'b0;

        // Recover by reset, then reset again during a busywait
        RESET = 1'b0;
        #1;
        check("rec_misal", 32'(MISALIGNED), 32'd0);
        check("rec_pc", PC, 32'h0);
        tick(); RESET = 1'b1;
        tick();
        wait_valid(10, n);
        check("rec_instr", INSTRUCTION, mem[0]);
        cfg_wait = 5;
        consume(1'b0, 32'h0);
        tick(); tick();
        check("mid_busy", 32'(IMEM_BUSYWAIT), 32'd1);
        check("mid_read", 32'(IMEM_READ), 32'd1);
        RESET = 1'b0;
        #1;
        check("async_read", 32'(IMEM_READ), 32'd0);
        check("async_pc", PC, 32'h0);
        check("async_instr", INSTRUCTION, 32'h0);
        tick(); tick();
        cfg_wait = 0;
        RESET = 1'b1;
        tick();
        check("restart_instr", INSTRUCTION, 32'h0);
        check("restart_read", 32'(IMEM_READ), 32'd1);
        check("restart_addr", 32'(IMEM_ADDR), 32'h0);
        wait_valid(10, n);
        check("restart_pc", PC, 32'h0);
        check("restart_word", INSTRUCTION, mem[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

CPU-side initiator of the instruction-fetch interface. Owns the program counter, issues word reads to a multi-cycle instruction memory using a read/busywait handshake, and presents each fetched instruction to the CPU core with a valid flag. Sits between the `cpu` datapath/control and the instruction memory. Replaces the zero-latency fetch path so the core tolerates variable memory latency and stalls.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset; must be word aligned.
- `IMEM_AW`, default 8: instruction memory word-address width (256 words = 1024 bytes).
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RESET`  in  1: reset, asynchronous and active-low.
- `PC`  out  32: byte address of the instruction being fetched or presented.
- `INSTRUCTION`  out  32: fetched instruction word; valid only while `INSTR_VALID`=1.
- `INSTR_VALID`  out  1: `INSTRUCTION` holds the word at `PC`.
- `STALL`  in  1: core cannot accept the presented instruction this cycle.
- `BRANCH_TAKEN`  in  1: redirect; sampled only on a consume edge.
- `BRANCH_TARGET`  in  32: redirect byte address.
- `MISALIGNED`  out  1: sticky error, taken branch to a non-word-aligned target.
- `IMEM_READ`  out  1: read request to instruction memory.
- `IMEM_ADDR`  out  IMEM_AW: word address, equal to `PC[IMEM_AW+1:2]`.
- `IMEM_READDATA`  in  32: memory read data.
- `IMEM_BUSYWAIT`  in  1: memory not ready; transfer completes on an edge where `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0.

## Operation
- States: IDLE, FETCH, HOLD, ERROR.
- IDLE: reset state, `IMEM_READ`=0. Unconditionally goes to FETCH on the first edge after `RESET` deasserts.
- FETCH: `IMEM_READ`=1, `IMEM_ADDR` held constant.
  - Edge with `IMEM_BUSYWAIT`=1: stay in FETCH.
  - Edge with `IMEM_BUSYWAIT`=0: capture `IMEM_READDATA` into `INSTRUCTION` and go to HOLD.
- HOLD: `INSTR_VALID`=1, `IMEM_READ`=0.
  - Consume means `STALL`=0 at the edge.
  - On consume with `BRANCH_TAKEN`=0: `PC` <= `PC`+4, go to FETCH.
  - On consume with `BRANCH_TAKEN`=1 and `BRANCH_TARGET[1:0]`=0: `PC` <= `BRANCH_TARGET`, go to FETCH.
  - On consume with `BRANCH_TAKEN`=1 and a misaligned target: `PC` <= `BRANCH_TARGET`, set `MISALIGNED`, go to ERROR.
  - While `STALL`=1: `PC`, `INSTRUCTION` and `INSTR_VALID` are held.
- ERROR: `INSTR_VALID`=0, `IMEM_READ`=0. Left only by reset.
- Width rules:
  - `PC`+4 wraps modulo 2^32.
  - `IMEM_ADDR` drops `PC[31:IMEM_AW+2]`, so addresses above the memory alias.
  - `PC[1:0]` is always 0 except in ERROR.
- `BRANCH_TAKEN` and `STALL` are ignored outside HOLD.

## Timing
- Reset values, applied immediately on `RESET`=0:
  - `PC`=`RESET_PC`, `INSTRUCTION`=0.
  - `INSTR_VALID`=0, `MISALIGNED`=0, `IMEM_READ`=0.
  - State = IDLE.
- `IMEM_READ`, `IMEM_ADDR` and `INSTR_VALID` are decoded from registered state and `PC` only. There is no combinational path from any input to any output.
- Latency:
  - First `IMEM_READ` is high in the cycle after the first edge following reset release.
  - With zero-wait memory, `INSTR_VALID` rises 1 cycle after `IMEM_READ` rises.
  - Each busywait cycle adds 1 cycle.
  - Peak throughput is 1 instruction per 2 cycles.
- Reset mid-FETCH: `IMEM_READ` drops asynchronously. Memory must abandon the outstanding read. Any data returned afterwards is ignored.
- `INSTRUCTION` changes only on the FETCH->HOLD edge or on reset.

## Structure
- Shared package `cpu_fetch_pkg`:
  - fetch state encoding (IDLE/FETCH/HOLD/ERROR);
  - `INSTR_W`=32, `PC_W`=32, `PC_INC`=4.
- The package is also imported by the core and by the memory model.
- Single module. No sub-module.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory holding 32'h0004_0005 at word 0 -> `INSTR_VALID`=1 with `INSTRUCTION`=32'h0004_0005, `PC`=0, 2 cycles after reset release.
- Memory with 3 busywait cycles per read -> `IMEM_ADDR` stable for 4 cycles; next `PC`=4; 5 cycles between consumes.
- `STALL`=1 for 6 cycles in HOLD -> `PC`, `INSTRUCTION` and `INSTR_VALID` unchanged, no `IMEM_READ`; consume on `STALL` release.
- Consume at `PC`=8 with `BRANCH_TAKEN`=1, `BRANCH_TARGET`=32'h40 -> `PC`=32'h40, `IMEM_ADDR`=8'h10.
- `BRANCH_TARGET`=32'h42 taken -> `MISALIGNED`=1, state ERROR, `IMEM_READ` stays 0 until reset; `PC` at 32'hFFFF_FFFC consumes to 0.
- Assert `RESET` during a busywait -> `IMEM_READ`=0 immediately; late read data is ignored; restart fetches from `RESET_PC`.
